// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan sampler and its settle counter.
// The FSM state encoding and the channel geometry of the 4-to-1 mux stage.
package mux_scan_pkg;

  // Encoding 2'd3 is unused and is decoded as IDLE.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;

  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;

endpackage

// File: rtl/mux_scan_sampler_settle_counter.sv
// Settle interval counter: clear forces zero, en counts up.
// done is combinational once the last settle cycle is reached.
module settle_counter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign done = (cnt_reg == LAST);

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans the four mux channels via sel, waits a settle window on each,
// samples m_in and publishes the assembled word with a valid pulse and self-check.
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       continuous,
  input  logic       m_in,
  input  logic [3:0] expected,
  output logic [1:0] sel,
  output logic [3:0] data_out,
  output logic       valid,
  output logic       mismatch,
  output logic       busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [NUM_CH-1:0] shadow_reg;
  logic [NUM_CH-1:0] word;
  logic              settle_en;
  logic              settle_done;

  // The counter only runs inside SETTLE and sits at zero everywhere else.
  assign settle_en = (state_reg == S_SETTLE);

  settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_settle (
    .clock (clock),
    .resetn(resetn),
    .clear (!settle_en),
    .en    (settle_en),
    .done  (settle_done)
  );

  assign word = {m_in, shadow_reg[NUM_CH-2:0]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_SETTLE: begin
        if (settle_done) begin
          state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (idx_reg != LAST_IDX) begin
          state_next = S_SETTLE;
        end else begin
          state_next = continuous ? S_SETTLE : S_IDLE;
        end
      end
      default: begin
        state_next = start ? S_SETTLE : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      shadow_reg <= '0;
      sel        <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      mismatch   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != S_IDLE);
      valid     <= 1'b0;
      case (state_reg)
        S_SETTLE: begin
        end
        S_SAMPLE: begin
          shadow_reg[idx_reg] <= m_in;
          if (idx_reg != LAST_IDX) begin
            idx_reg <= idx_reg + IDX_W'(1);
            sel     <= idx_reg + IDX_W'(1);
          end else begin
            data_out <= word;
            mismatch <= (word != expected);
            valid    <= 1'b1;
            idx_reg  <= '0;
            // Returning to IDLE leaves sel on the last channel.
            if (continuous) begin
              sel <= '0;
            end
          end
        end
        default: begin
          if (start) begin
            idx_reg <= '0;
            sel     <= '0;
          end
        end
      endcase
    end
  end

endmodule
